// File: rtl/btn_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : btn_irq_ctrl
// Description : IPIF user-logic slave for up to 16 push-buttons.
//               Each channel: 2-FF synchroniser, tick-sampled debounce
//               filter with a consecutive-sample count, and press/release
//               edge detection. Events latch into a W1C register and drive
//               one registered level interrupt through an enable mask.
//               The sample divider is software-programmable at run time.
// Ports       : Bus2IP_Clk    - the only clock (rising edge)
//               Bus2IP_Reset  - synchronous active-high reset
//               Bus2IP_Data   - write data
//               Bus2IP_BE     - byte enables (writes need all ones)
//               Bus2IP_RdCE   - read enables, bit[3]=0x00 .. bit[0]=0x0C
//               Bus2IP_WrCE   - write enables, same ordering
//               IP2Bus_Data   - read data (0 unless exactly one RdCE set)
//               IP2Bus_RdAck  - same-cycle read acknowledge
//               IP2Bus_WrAck  - same-cycle write acknowledge
//               IP2Bus_Error  - write to read-only STATE
//               btn           - raw asynchronous buttons, active-high
//               irq           - registered level interrupt
// Registers   : 0x00 STATE RO, 0x04 EVENT W1C, 0x08 IE RW, 0x0C CFG RW
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module btn_irq_ctrl #(
  parameter int          C_NUM_REG    = 4,
  parameter int          C_SLV_DWIDTH = 32,
  parameter int          C_NUM_BTN    = 3,
  parameter int          C_DIV_W      = 18,
  parameter int unsigned C_DIV_RST    = 2**18 - 1,
  parameter int          C_DB_CNT     = 4
) (
  input  logic                      Bus2IP_Clk,
  input  logic                      Bus2IP_Reset,
  input  logic [C_SLV_DWIDTH-1:0]   Bus2IP_Data,
  input  logic [C_SLV_DWIDTH/8-1:0] Bus2IP_BE,
  input  logic [C_NUM_REG-1:0]      Bus2IP_RdCE,
  input  logic [C_NUM_REG-1:0]      Bus2IP_WrCE,
  output logic [C_SLV_DWIDTH-1:0]   IP2Bus_Data,
  output logic                      IP2Bus_RdAck,
  output logic                      IP2Bus_WrAck,
  output logic                      IP2Bus_Error,
  input  logic [C_NUM_BTN-1:0]      btn,
  output logic                      irq
);

  localparam int                      C_CNT_W    = 4;
  localparam logic [C_CNT_W-1:0]      C_DB_LAST  = C_CNT_W'(C_DB_CNT - 1);
  localparam logic [15:0]             C_BTN_MASK = 16'((32'd1 << C_NUM_BTN) - 32'd1);
  // Press bits live in [15:0], release bits in [31:16].
  localparam logic [C_SLV_DWIDTH-1:0] C_EV_MASK  = C_SLV_DWIDTH'({C_BTN_MASK, C_BTN_MASK});

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [C_NUM_BTN-1:0]    sync1_q;
  logic [C_NUM_BTN-1:0]    sync2_q;
  logic [C_DIV_W-1:0]      div_q,    div_d;
  logic [C_DIV_W-1:0]      divcnt_q, divcnt_d;
  logic [C_NUM_BTN-1:0]    state_q,  state_d;
  logic [C_CNT_W-1:0]      fcnt_q [C_NUM_BTN];
  logic [C_CNT_W-1:0]      fcnt_d [C_NUM_BTN];
  logic [C_SLV_DWIDTH-1:0] ev_q,     ev_d;
  logic [C_SLV_DWIDTH-1:0] ie_q,     ie_d;
  logic                    irq_q,    irq_d;

  // --------------------------------------------------------------------------
  // Bus decode: a write lands only with every byte lane enabled, but the
  // acknowledge is returned regardless.
  // --------------------------------------------------------------------------
  logic be_full;
  logic wr_event;
  logic wr_ie;
  logic wr_cfg;

  assign be_full  = &Bus2IP_BE;
  assign wr_event = Bus2IP_WrCE[2] & be_full;
  assign wr_ie    = Bus2IP_WrCE[1] & be_full;
  assign wr_cfg   = Bus2IP_WrCE[0] & be_full;

  assign IP2Bus_RdAck = |Bus2IP_RdCE;
  assign IP2Bus_WrAck = |Bus2IP_WrCE;
  assign IP2Bus_Error = Bus2IP_WrCE[3];

  // --------------------------------------------------------------------------
  // Sample divider: tick while the down-counter sits at zero.
  // --------------------------------------------------------------------------
  logic tick;
  assign tick = (divcnt_q == '0);

  always_comb begin
    div_d    = div_q;
    divcnt_d = divcnt_q;
    if (wr_cfg) begin
      // A new divider takes effect immediately rather than after the
      // current (possibly very long) period has run out.
      div_d    = Bus2IP_Data[C_DIV_W-1:0];
      divcnt_d = Bus2IP_Data[C_DIV_W-1:0];
    end else if (tick) begin
      divcnt_d = div_q;
    end else begin
      divcnt_d = divcnt_q - 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Debounce filter: a new level is accepted only after C_DB_CNT consecutive
  // ticks disagree with the current state; any agreeing tick restarts it.
  // --------------------------------------------------------------------------
  logic [C_NUM_BTN-1:0] press;
  logic [C_NUM_BTN-1:0] release_ev;

  always_comb begin
    state_d    = state_q;
    press      = '0;
    release_ev = '0;
    for (int i = 0; i < C_NUM_BTN; i++) begin
      fcnt_d[i] = fcnt_q[i];
    end
    if (tick) begin
      for (int i = 0; i < C_NUM_BTN; i++) begin
        if (sync2_q[i] == state_q[i]) begin
          fcnt_d[i] = '0;
        end else if (fcnt_q[i] == C_DB_LAST) begin
          state_d[i]    = sync2_q[i];
          fcnt_d[i]     = '0;
          press[i]      = sync2_q[i];
          release_ev[i] = ~sync2_q[i];
        end else begin
          fcnt_d[i] = fcnt_q[i] + 1'b1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // EVENT / IE / IRQ. Setting is applied after clearing so a new event
  // survives a W1C of the same bit in the same cycle.
  // --------------------------------------------------------------------------
  logic [C_SLV_DWIDTH-1:0] ev_set;
  logic [C_SLV_DWIDTH-1:0] ev_clr;

  always_comb begin
    ev_set                  = '0;
    ev_set[C_NUM_BTN-1:0]   = press;
    ev_set[16 +: C_NUM_BTN] = release_ev;
    ev_clr                  = wr_event ? Bus2IP_Data : '0;
    ev_d                    = ((ev_q & ~ev_clr) | ev_set) & C_EV_MASK;
    ie_d                    = wr_ie ? (Bus2IP_Data & C_EV_MASK) : ie_q;
    irq_d                   = |(ev_q & ie_q);
  end

  assign irq = irq_q;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge Bus2IP_Clk) begin
    if (Bus2IP_Reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      div_q    <= C_DIV_W'(C_DIV_RST);
      divcnt_q <= '0;
      state_q  <= '0;
      for (int i = 0; i < C_NUM_BTN; i++) begin
        fcnt_q[i] <= '0;
      end
      ev_q     <= '0;
      ie_q     <= '0;
      irq_q    <= 1'b0;
    end else begin
      sync1_q  <= btn;
      sync2_q  <= sync1_q;
      div_q    <= div_d;
      divcnt_q <= divcnt_d;
      state_q  <= state_d;
      for (int i = 0; i < C_NUM_BTN; i++) begin
        fcnt_q[i] <= fcnt_d[i];
      end
      ev_q     <= ev_d;
      ie_q     <= ie_d;
      irq_q    <= irq_d;
    end
  end

  // --------------------------------------------------------------------------
  // Read mux: only a one-hot RdCE selects a register.
  // --------------------------------------------------------------------------
  always_comb begin
    IP2Bus_Data = '0;
    case (Bus2IP_RdCE)
      4'b1000: IP2Bus_Data = C_SLV_DWIDTH'(state_q);
      4'b0100: IP2Bus_Data = ev_q;
      4'b0010: IP2Bus_Data = ie_q;
      4'b0001: IP2Bus_Data = C_SLV_DWIDTH'(div_q);
      default: IP2Bus_Data = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_btn_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_btn_irq_ctrl
// Description : Self-checking bench for btn_irq_ctrl (3 buttons, 4-tick
//               debounce). A cycle-level behavioural model is compared with
//               the DUT outputs every cycle; directed register reads pin
//               hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_btn_irq_ctrl;

  localparam int          NB      = 3;
  localparam int          DB      = 4;
  localparam logic [31:0] DIV_RST = 32'h0003_FFFF;
  localparam logic [31:0] EV_MSK  = 32'h0007_0007;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [3:0]  rdce;
  logic [3:0]  wrce;
  logic [31:0] rdata;
  logic        rdack;
  logic        wrack;
  logic        err;
  logic [2:0]  btn;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;
  logic last_err;
  logic last_ack;

  btn_irq_ctrl #(
    .C_NUM_REG   (4),
    .C_SLV_DWIDTH(32),
    .C_NUM_BTN   (NB),
    .C_DIV_W     (18),
    .C_DIV_RST   (2**18 - 1),
    .C_DB_CNT    (DB)
  ) dut (
    .Bus2IP_Clk  (clk),
    .Bus2IP_Reset(rst),
    .Bus2IP_Data (wdata),
    .Bus2IP_BE   (be),
    .Bus2IP_RdCE (rdce),
    .Bus2IP_WrCE (wrce),
    .IP2Bus_Data (rdata),
    .IP2Bus_RdAck(rdack),
    .IP2Bus_WrAck(wrack),
    .IP2Bus_Error(err),
    .btn         (btn),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model: delay line for the synchroniser, period counter for
  // the sample tick, and a run length of disagreeing samples per button.
  // --------------------------------------------------------------------------
  logic [2:0]  m_sy1, m_s, m_state;
  logic [17:0] m_div, m_cnt;
  logic [31:0] m_ev, m_ie;
  logic        m_irq;
  int          m_run [NB];

  always @(posedge clk) begin : model
    logic        tk;
    logic        wok;
    logic        nirq;
    logic [31:0] set;
    logic [2:0]  nstate;
    if (rst) begin
      m_sy1   = '0;
      m_s     = '0;
      m_state = '0;
      m_ev    = '0;
      m_ie    = '0;
      m_div   = DIV_RST[17:0];
      m_cnt   = '0;
      m_irq   = 1'b0;
      for (int i = 0; i < NB; i++) m_run[i] = 0;
    end else begin
      tk     = (m_cnt == 0);
      set    = '0;
      nstate = m_state;
      if (tk) begin
        for (int i = 0; i < NB; i++) begin
          if (m_s[i] != m_state[i]) begin
            m_run[i]++;
            if (m_run[i] == DB) begin
              nstate[i] = m_s[i];
              m_run[i]  = 0;
              if (m_s[i]) set[i] = 1'b1;
              else        set[16 + i] = 1'b1;
            end
          end else begin
            m_run[i] = 0;
          end
        end
      end
      wok  = (be == 4'hF);
      nirq = |(m_ev & m_ie);
      if (wrce[2] && wok) m_ev = m_ev & ~wdata;
      m_ev = (m_ev | set) & EV_MSK;
      if (wrce[1] && wok) m_ie = wdata & EV_MSK;
      if (wrce[0] && wok) begin
        m_div = wdata[17:0];
        m_cnt = wdata[17:0];
      end else if (tk) begin
        m_cnt = m_div;
      end else begin
        m_cnt = m_cnt - 18'd1;
      end
      m_irq   = nirq;
      m_state = nstate;
      m_s     = m_sy1;
      m_sy1   = btn;
    end
  end

  function automatic logic [31:0] exp_rd(input logic [3:0] ce);
    case (ce)
      4'b1000: return {29'd0, m_state};
      4'b0100: return m_ev;
      4'b0010: return m_ie;
      4'b0001: return {14'd0, m_div};
      default: return 32'd0;
    endcase
  endfunction

  // Every-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("irq",     {31'd0, irq},   {31'd0, m_irq});
      check("rd_data", rdata,          exp_rd(rdce));
      check("rd_ack",  {31'd0, rdack}, {31'd0, |rdce});
      check("wr_ack",  {31'd0, wrack}, {31'd0, |wrce});
      check("error",   {31'd0, err},   {31'd0, wrce[3]});
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers (all inputs change 1 time unit after a rising edge)
  // --------------------------------------------------------------------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // idx: 0=STATE 1=EVENT 2=IE 3=CFG
  task automatic wr(input int idx, input logic [31:0] d, input logic [3:0] b);
    wrce  = 4'b1000 >> idx;
    wdata = d;
    be    = b;
    @(negedge clk);
    last_err = err;
    last_ack = wrack;
    cyc();
    wrce  = '0;
    wdata = '0;
    be    = 4'hF;
  endtask

  task automatic rdchk(input string name, input int idx, input logic [31:0] exp);
    rdce = 4'b1000 >> idx;
    @(negedge clk);
    check(name, rdata, exp);
    cyc();
    rdce = '0;
  endtask

  task automatic irqchk(input string name, input logic exp);
    @(negedge clk);
    check(name, {31'd0, irq}, {31'd0, exp});
    cyc();
  endtask

  localparam int R_STATE = 0;
  localparam int R_EVENT = 1;
  localparam int R_IE    = 2;
  localparam int R_CFG   = 3;

  initial begin
    rst   = 1'b1;
    btn   = '0;
    wdata = '0;
    be    = 4'hF;
    rdce  = '0;
    wrce  = '0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;

    // T1: reset values
    rdchk("t1_state", R_STATE, 32'h0);
    rdchk("t1_event", R_EVENT, 32'h0);
    rdchk("t1_ie",    R_IE,    32'h0);
    rdchk("t1_cfg",   R_CFG,   32'h0003_FFFF);
    irqchk("t1_irq", 1'b0);
    wr(R_CFG, 32'd3, 4'hF);
    rdchk("cfg_3", R_CFG, 32'd3);

    // T2: press with IE set, then W1C
    wr(R_IE, 32'h1, 4'hF);
    btn[0] = 1'b1;
    repeat (30) cyc();
    rdchk("t2_state", R_STATE, 32'h1);
    rdchk("t2_event", R_EVENT, 32'h1);
    irqchk("t2_irq_on", 1'b1);
    wr(R_EVENT, 32'h1, 4'hF);
    irqchk("t2_irq_hold", 1'b1);
    irqchk("t2_irq_off", 1'b0);
    rdchk("t2_event_clr", R_EVENT, 32'h0);

    // T3: 3-tick high, 1-tick low glitch, then a full 4-tick run
    btn[1] = 1'b1;
    repeat (12) cyc();
    btn[1] = 1'b0;
    rdchk("t3_state_a", R_STATE, 32'h1);
    repeat (3) cyc();
    btn[1] = 1'b1;
    rdchk("t3_state_b", R_STATE, 32'h1);
    repeat (29) cyc();
    rdchk("t3_event", R_EVENT, 32'h2);
    rdchk("t3_state", R_STATE, 32'h3);

    // T4: press + release with IE masked, then enable release bit
    wr(R_EVENT, 32'hFFFF_FFFF, 4'hF);
    wr(R_IE, 32'h0, 4'hF);
    btn[2] = 1'b1;
    repeat (30) cyc();
    btn[2] = 1'b0;
    repeat (30) cyc();
    rdchk("t4_event", R_EVENT, 32'h0004_0004);
    irqchk("t4_irq_masked", 1'b0);
    wr(R_IE, 32'h0004_0000, 4'hF);
    irqchk("t4_irq_lat", 1'b0);
    irqchk("t4_irq_on", 1'b1);
    wr(R_IE, 32'h0, 4'hF);
    wr(R_EVENT, 32'hFFFF_FFFF, 4'hF);

    // T6: tick every cycle; press accepted on the 4th cycle after s rises
    wr(R_CFG, 32'd0, 4'hF);
    btn[0] = 1'b0;
    repeat (10) cyc();
    wr(R_EVENT, 32'hFFFF_FFFF, 4'hF);
    btn[0] = 1'b1;
    repeat (5) cyc();
    rdchk("t6_state_before", R_STATE, 32'h2);
    rdchk("t6_state_after",  R_STATE, 32'h3);

    // T5: W1C lands on the same edge the press sets -> bit stays set
    btn[0] = 1'b0;
    repeat (10) cyc();
    wr(R_EVENT, 32'hFFFF_FFFF, 4'hF);
    btn[0] = 1'b1;
    repeat (5) cyc();
    wr(R_EVENT, 32'h1, 4'hF);
    rdchk("t5_collide", R_EVENT, 32'h1);
    wr(R_STATE, 32'h0, 4'hF);
    check("t5_err", {31'd0, last_err}, 32'd1);
    check("t5_ack", {31'd0, last_ack}, 32'd1);
    rdchk("t5_state", R_STATE, 32'h3);

    // Partial byte enables are ignored
    wr(R_IE, 32'hFFFF_FFFF, 4'b0011);
    rdchk("be_ie", R_IE, 32'h0);
    wr(R_CFG, 32'd5, 4'b0001);
    rdchk("be_cfg", R_CFG, 32'h0);
    wr(R_EVENT, 32'h1, 4'b1110);
    rdchk("be_event", R_EVENT, 32'h1);

    // Non-one-hot read returns zero but is acknowledged
    rdce = 4'b0110;
    @(negedge clk);
    check("multi_rd_data", rdata, 32'h0);
    check("multi_rd_ack", {31'd0, rdack}, 32'd1);
    cyc();
    rdce = '0;

    repeat (5) cyc();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
